// File: rtl/uart_tx_sched.sv
// Byte scheduler feeding a single UART transmitter from a FIFO shared by a
// non-stallable CPU store port and a ready/valid secondary requester.
module uart_tx_sched #(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                     CLK,
    input  logic                     NRST,
    input  logic                     cpu_we,
    input  logic [7:0]               cpu_data,
    output logic                     cpu_drop,
    input  logic                     hc_valid,
    input  logic [7:0]               hc_data,
    output logic                     hc_ready,
    input  logic                     uart_busy,
    output logic                     uart_wr,
    output logic [7:0]               uart_dat,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        ACK,
        DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            uart_wr_q, uart_wr_d;
    logic [7:0]      uart_dat_q, uart_dat_d;
    logic [7:0]      mem_q [DEPTH];

    logic            full, empty;
    logic            push, pop;
    logic [7:0]      push_data;

    // Full/empty come from the registered count only, so a pop in the same
    // cycle never frees a slot for the CPU byte arriving alongside it.
    always_comb begin
        full      = (count_q == FULL_CNT);
        empty     = (count_q == '0);
        cpu_drop  = cpu_we & full;
        hc_ready  = ~full & ~cpu_we;
        push      = (cpu_we & ~full) | (hc_valid & ~full & ~cpu_we);
        push_data = cpu_we ? cpu_data : hc_data;
        pop       = (state_q == SEND);
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        tmo_d      = tmo_q;
        uart_wr_d  = 1'b0;
        uart_dat_d = 8'h00;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (!empty && !uart_busy) begin
                    state_d    = SEND;
                    uart_wr_d  = 1'b1;
                    uart_dat_d = mem_q[rd_ptr_q];
                end
            end
            SEND: begin
                state_d = ACK;
                tmo_d   = '0;
            end
            ACK: begin
                // A UART that never acknowledges still counts the byte as sent.
                if (uart_busy) begin
                    state_d = DRAIN;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!uart_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tmo_q      <= '0;
            uart_wr_q  <= 1'b0;
            uart_dat_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
            uart_wr_q  <= uart_wr_d;
            uart_dat_q <= uart_dat_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are valid, so stale data is never read.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign uart_wr    = uart_wr_q;
    assign uart_dat   = uart_dat_q;
    assign fifo_count = count_q;

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 4, max cycles to wait for uart_busy rise after a write strobe.
REQ-003 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port NRST  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cpu_we  input  1  CPU store to UART address; single-cycle; cannot stall.
REQ-006 SHALL have port cpu_data  input  8  CPU byte, valid with cpu_we.
REQ-007 SHALL have port cpu_drop  output  1  one-cycle pulse: CPU byte discarded because FIFO full.
REQ-008 SHALL have port hc_valid  input  1  secondary requester (counter report engine) byte valid.
REQ-009 SHALL have port hc_data  input  8  secondary byte, valid with hc_valid.
REQ-010 SHALL have port hc_ready  output  1  secondary byte accepted this cycle when hc_valid&hc_ready.
REQ-011 SHALL have port uart_busy  input  1  UART transmitter busy.
REQ-012 SHALL have port uart_wr  output  1  one-cycle write strobe to UART.
REQ-013 SHALL have port uart_dat  output  8  byte to UART, valid while uart_wr=1.
REQ-014 SHALL have port fifo_count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL hold bytes in a DEPTH-entry FIFO, first-in first-out, with wrapping read/write pointers.
REQ-016 SHALL define full as fifo_count==DEPTH and empty as fifo_count==0, both from registered count.
REQ-017 SHALL push at most one byte per cycle; CPU has fixed priority over secondary.
REQ-018 SHALL push cpu_data when cpu_we=1 and not full.
REQ-019 SHALL assert cpu_drop combinationally in the same cycle when cpu_we=1 and full; byte is not stored.
REQ-020 SHALL drive hc_ready = !full & !cpu_we; push hc_data when hc_valid&hc_ready.
REQ-021 SHALL keep fifo_count unchanged when a push and a pop occur in the same cycle.
REQ-022 SHALL not bypass: a byte pushed in cycle N is first poppable in cycle N+1.
REQ-023 SHALL run output FSM with states IDLE, SEND, ACK, DRAIN.
REQ-024 IDLE: go to SEND when !empty & !uart_busy; else stay.
REQ-025 SEND: uart_wr=1, uart_dat=FIFO head, pop head, go to ACK; lasts exactly one cycle.
REQ-026 ACK: go to DRAIN when uart_busy=1; go to IDLE after ACK_TIMEOUT cycles in ACK without busy (byte counted as sent, not retried).
REQ-027 DRAIN: go to IDLE when uart_busy=0.
REQ-028 SHALL hold uart_wr=0 in all states other than SEND; uart_dat=8'h00 outside SEND.
REQ-029 SHALL give minimum latency cpu_we (cycle N, FIFO empty, FSM IDLE, uart_busy=0) -> uart_wr=1 in cycle N+2.
REQ-030 SHALL never issue a second uart_wr before the FSM has returned to IDLE.

Reset
REQ-031 SHALL, while NRST=0, asynchronously force FSM=IDLE, pointers=0, fifo_count=0, timeout counter=0, uart_wr=0, uart_dat=0, cpu_drop=0.
REQ-032 SHALL discard FIFO contents and any in-flight SEND/ACK/DRAIN on reset; no strobe is issued on reset release.
REQ-033 SHALL drive hc_ready=1 in the first cycle after reset release when cpu_we=0.

Verification
REQ-034 Single byte: reset, cpu_we=1 cpu_data=8'h41 at cycle 0, uart_busy rises cycle 3, falls cycle 10 -> uart_wr=1 with uart_dat=8'h41 in cycle 2 only; FSM IDLE in cycle 11.
REQ-035 Overflow: uart_busy=1 held, 9 consecutive cpu_we writes 8'h00..8'h08 -> fifo_count reaches 8, cpu_drop=1 only on 9th write; after release bytes 00..07 emerge in order.
REQ-036 Priority: cpu_we=1 and hc_valid=1 in same cycle for 3 cycles -> hc_ready=0 those cycles, only CPU bytes stored; hc byte accepted first cycle cpu_we=0.
REQ-037 Timeout: uart_busy tied 0, two bytes queued -> second uart_wr exactly ACK_TIMEOUT+2 cycles after first (SEND, 4x ACK, IDLE, SEND).
REQ-038 Simultaneous push/pop at fifo_count=8: pop in SEND while cpu_we=1 -> cpu_drop=1 (full from registered count), fifo_count becomes 7.
REQ-039 Reset mid-operation: NRST low during DRAIN with 5 bytes queued -> uart_wr=0, fifo_count=0 immediately; no uart_wr after release until new push.
